di_port_arbiter: RTL and testbench
==================================

// Module: di_port_arbiter
// PURPOSE
// Shares one downstream DI terminal (word side of the byte serializer) between NPORTS
// upstream DI masters. A master requests by asserting read_mode or write_mode; the winner
// owns the downstream port until both its modes drop. Round-robin, non-preemptive, with a
// release gap so the serializer sees modes low and clears, plus an inactivity watchdog.
// PARAMETERS
// NPORTS         2    number of upstream masters (2..8)
// DI_DATA_WIDTH  32   DI data width, 16 or 32
// GAP_CYCLES     2    cycles downstream modes held low between grants (>=1)
// WDOG_CYCLES    4096 idle cycles in GRANT before forced release (0 = disabled)
// PORTS
// ifclk          in   1               clock; all logic posedge
// reset          in   1               async active-high reset
// up_len         in   32*NPORTS       per-port transfer length, port i at [32*i+:32]
// up_write_mode  in   NPORTS          per-port write mode
// up_write       in   NPORTS          per-port write strobe
// up_reg_datai   in   DW*NPORTS       per-port write data
// up_write_rdy   out  NPORTS          per-port write ready
// up_read_mode   in   NPORTS          per-port read mode
// up_read_req    in   NPORTS          per-port read request
// up_read        in   NPORTS          per-port read strobe
// up_reg_datao   out  DW*NPORTS       per-port read data
// up_read_rdy    out  NPORTS          per-port read ready
// dn_len, dn_write_mode, dn_write, dn_reg_datai, dn_read_mode, dn_read_req, dn_read
//                out  32/1/1/DW/1/1/1 downstream DI master signals
// dn_write_rdy, dn_read_rdy  in 1     downstream ready; dn_reg_datao in DW read data
// grant          out  NPORTS          one-hot current owner (0 when none)
// busy           out  1               state != IDLE
// wdog_pulse     out  1               one-cycle pulse on watchdog release
// BEHAVIOUR
// - Reset: state IDLE, grant=0, rr pointer=0, lockout=0, all outputs 0.
// - States IDLE -> GRANT -> GAP -> IDLE. req[i] = (read_mode|write_mode)[i] & ~lockout[i].
// - IDLE: any req -> pick first req at/after rr pointer (wrapping); grant registered, GRANT
//   next cycle. Request seen cycle N => dn modes asserted cycle N+1.
// - GRANT: dn_* = granted port's inputs (combinational mux on registered grant); granted
//   port's rdy/datao = dn_*; non-granted ports: rdy=0, datao=0. If granted port has both
//   modes set, read wins: dn_write_mode=0, dn_write=0.
// - GRANT exit: granted port's modes both low -> GAP, rr pointer = owner+1 mod NPORTS.
// - Watchdog: counter clears on any granted write/read_req/read strobe, increments otherwise;
//   reaching WDOG_CYCLES -> GAP, wdog_pulse=1, lockout[owner]=1. lockout[i] clears when
//   port i drops both modes.
// - GAP: all dn_* = 0, grant=0, all up rdy=0; lasts exactly GAP_CYCLES then IDLE. New
//   requests during GAP wait; a mode drop during GAP is not a request.
// - dn_len passes through unmodified; no data buffering, mux adds zero latency.
// - Reset mid-grant: outputs return to 0 asynchronously; downstream sees modes low.
// TESTING
// - P0 and P1 assert write_mode same cycle from reset -> grant=01 next cycle; after P0 drops
//   mode, dn modes low 2 cycles, then grant=10.
// - P1 holds read_mode, P0 requests during P1 grant -> P0 granted only after P1 release+gap.
// - Alternate P0/P1 back-to-back requests 8 times -> grants strictly alternate.
// - P0 write 3 words, len=3 -> dn_write mirrors up_write[0], up_write_rdy[0]=dn_write_rdy,
//   up_write_rdy[1]=0 throughout.
// - WDOG_CYCLES=16, P0 holds mode without strobes -> wdog_pulse at 16th idle cycle, P0 not
//   regranted until its mode drops and re-rises; P1 request served meanwhile.
// - reset asserted mid read on P1 -> grant=0, dn_read_mode=0 immediately; rr pointer=0.

Source files
------------

// File: rtl/di_port_arbiter_if.sv
// Bundle for the upstream DI masters, the shared downstream DI terminal
// and the arbiter status outputs. Port i of each per-port field is element [i].
interface di_port_arbiter_if #(
   parameter int NPORTS = 2,
   parameter int DW     = 32
);
   // upstream side, one lane per master
   logic [NPORTS-1:0][31:0]   up_len;
   logic [NPORTS-1:0]         up_write_mode;
   logic [NPORTS-1:0]         up_write;
   logic [NPORTS-1:0][DW-1:0] up_reg_datai;
   logic [NPORTS-1:0]         up_write_rdy;
   logic [NPORTS-1:0]         up_read_mode;
   logic [NPORTS-1:0]         up_read_req;
   logic [NPORTS-1:0]         up_read;
   logic [NPORTS-1:0][DW-1:0] up_reg_datao;
   logic [NPORTS-1:0]         up_read_rdy;
   // downstream side, toward the byte serializer
   logic [31:0]               dn_len;
   logic                      dn_write_mode;
   logic                      dn_write;
   logic [DW-1:0]             dn_reg_datai;
   logic                      dn_write_rdy;
   logic                      dn_read_mode;
   logic                      dn_read_req;
   logic                      dn_read;
   logic [DW-1:0]             dn_reg_datao;
   logic                      dn_read_rdy;
   // status
   logic [NPORTS-1:0]         grant;
   logic                      busy;
   logic                      wdog_pulse;

   // upstream masters + downstream terminal as seen by the environment
   modport master (
      output up_len, up_write_mode, up_write, up_reg_datai,
             up_read_mode, up_read_req, up_read,
             dn_write_rdy, dn_reg_datao, dn_read_rdy,
      input  up_write_rdy, up_reg_datao, up_read_rdy,
             dn_len, dn_write_mode, dn_write, dn_reg_datai,
             dn_read_mode, dn_read_req, dn_read,
             grant, busy, wdog_pulse
   );

   // the arbiter itself
   modport slave (
      input  up_len, up_write_mode, up_write, up_reg_datai,
             up_read_mode, up_read_req, up_read,
             dn_write_rdy, dn_reg_datao, dn_read_rdy,
      output up_write_rdy, up_reg_datao, up_read_rdy,
             dn_len, dn_write_mode, dn_write, dn_reg_datai,
             dn_read_mode, dn_read_req, dn_read,
             grant, busy, wdog_pulse
   );
endinterface

// File: rtl/di_port_arbiter.sv
// Round-robin, non-preemptive sharing of one downstream DI terminal between
// NPORTS upstream masters. An owner keeps the port until both its modes drop
// (or the inactivity watchdog fires); a fixed gap with all downstream modes low
// follows every grant so the serializer can clear.
module di_port_arbiter #(
   parameter int NPORTS        = 2,
   parameter int DI_DATA_WIDTH = 32,
   parameter int GAP_CYCLES    = 2,
   parameter int WDOG_CYCLES   = 4096
) (
   input logic                ifclk,
   input logic                reset,
   di_port_arbiter_if.slave   bus
);
   localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

   state_t            state_q, state_d;
   logic [NPORTS-1:0] grant_q, grant_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [IW-1:0]     rr_q, rr_d;
   logic [NPORTS-1:0] lockout_q, lockout_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [WW-1:0]     wdog_q, wdog_d;

   logic [NPORTS-1:0] mode, req;
   logic              pick_vld;
   logic [IW-1:0]     pick_idx;
   logic              own_mode, own_act, own_rd;
   logic              wdog_fire;
   int                idx;

   assign mode     = bus.up_read_mode | bus.up_write_mode;
   assign req      = mode & ~lockout_q;
   assign own_mode = mode[owner_q];
   assign own_rd   = bus.up_read_mode[owner_q];
   assign own_act  = bus.up_write[owner_q] | bus.up_read_req[owner_q] | bus.up_read[owner_q];

   // first requester at/after the rr pointer; scan descending so the nearest wins
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      idx      = 0;
      for (int k = NPORTS - 1; k >= 0; k--) begin
         idx = int'(rr_q) + k;
         if (idx >= NPORTS) idx = idx - NPORTS;
         if (req[idx]) begin
            pick_vld = 1'b1;
            pick_idx = IW'(idx);
         end
      end
   end

   // next-state: grant, release/watchdog, gap timing, lockout bookkeeping
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      rr_d      = rr_q;
      gap_d     = gap_q;
      wdog_d    = wdog_q;
      wdog_fire = 1'b0;
      // a locked-out port is forgiven once it lets go of both modes
      lockout_d = lockout_q & mode;
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               state_d           = S_GRANT;
               owner_d           = pick_idx;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               wdog_d            = '0;
            end
         end
         S_GRANT: begin
            // normal release has priority over a watchdog fire in the same cycle
            if (WDOG_CYCLES != 0 && own_mode && !own_act &&
                wdog_q == WW'(WDOG_CYCLES - 1)) begin
               wdog_fire          = 1'b1;
               lockout_d[owner_q] = 1'b1;
            end
            if (!own_mode || wdog_fire) begin
               state_d = S_GAP;
               grant_d = '0;
               gap_d   = '0;
               rr_d    = (owner_q == IW'(NPORTS - 1)) ? '0 : owner_q + 1'b1;
            end else if (own_act) begin
               wdog_d = '0;
            end else if (WDOG_CYCLES != 0) begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         S_GAP: begin
            if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_IDLE;
            else                              gap_d   = gap_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state registers; reset forces everything (and thus all outputs) to idle
   always_ff @(posedge ifclk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         owner_q   <= '0;
         rr_q      <= '0;
         lockout_q <= '0;
         gap_q     <= '0;
         wdog_q    <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         rr_q      <= rr_d;
         lockout_q <= lockout_d;
         gap_q     <= gap_d;
         wdog_q    <= wdog_d;
      end
   end

   // zero-latency mux: owner drives downstream only while in GRANT; read beats write
   always_comb begin
      bus.dn_len        = '0;
      bus.dn_write_mode = 1'b0;
      bus.dn_write      = 1'b0;
      bus.dn_reg_datai  = '0;
      bus.dn_read_mode  = 1'b0;
      bus.dn_read_req   = 1'b0;
      bus.dn_read       = 1'b0;
      bus.up_write_rdy  = '0;
      bus.up_read_rdy   = '0;
      bus.up_reg_datao  = '0;
      if (state_q == S_GRANT) begin
         bus.dn_len                = bus.up_len[owner_q];
         bus.dn_read_mode          = own_rd;
         bus.dn_read_req           = bus.up_read_req[owner_q];
         bus.dn_read               = bus.up_read[owner_q];
         bus.dn_write_mode         = bus.up_write_mode[owner_q] & ~own_rd;
         bus.dn_write              = bus.up_write[owner_q] & ~own_rd;
         bus.dn_reg_datai          = bus.up_reg_datai[owner_q];
         bus.up_write_rdy[owner_q] = bus.dn_write_rdy;
         bus.up_read_rdy[owner_q]  = bus.dn_read_rdy;
         bus.up_reg_datao[owner_q] = bus.dn_reg_datao;
      end
   end

   assign bus.grant      = grant_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.wdog_pulse = wdog_fire;

endmodule

// File: tb/tb_di_port_arbiter.sv
// Directed bench for di_port_arbiter: a per-cycle vector table for the basic
// grant/gap/mux behaviour, then hand sequences for alternation, watchdog
// lockout and asynchronous reset during a grant.
module tb_di_port_arbiter;
   localparam int NP = 2;
   localparam int DW = 32;

   logic ifclk = 1'b0;
   logic reset = 1'b1;
   always #5 ifclk = ~ifclk;

   di_port_arbiter_if #(.NPORTS(NP), .DW(DW)) bus();

   di_port_arbiter #(
      .NPORTS(NP), .DI_DATA_WIDTH(DW), .GAP_CYCLES(2), .WDOG_CYCLES(16)
   ) dut (
      .ifclk(ifclk),
      .reset(reset),
      .bus  (bus)
   );

   // one row = inputs held for one cycle and the outputs expected in that cycle
   typedef struct {
      logic [1:0] wm, rm, wr, rq, rd;
      logic       wi, ri;
      logic [1:0] g;
      logic       b;
      logic [4:0] dn;   // {write_mode, read_mode, write, read_req, read}
      logic [1:0] wro, rro;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   localparam logic [31:0] DO_VAL = 32'hC5C5_5C5C;
   localparam logic [31:0] DI0    = 32'hA0A0_0000;
   localparam logic [31:0] DI1    = 32'hB1B1_0001;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_grant(input int lim, output logic [1:0] g);
      g = bus.grant;
      for (int i = 0; i < lim && g == 2'b00; i++) begin
         @(negedge ifclk); #1;
         g = bus.grant;
      end
   endtask

   initial begin
      logic [1:0]  g, exp_g;
      logic [4:0]  dn_act;
      logic [31:0] e_len, e_di;
      logic [63:0] e_do;
      int          pulse_at;

      bus.up_len        = {32'd7, 32'd3};
      bus.up_reg_datai  = {DI1, DI0};
      bus.dn_reg_datao  = DO_VAL;
      bus.up_write_mode = '0; bus.up_read_mode = '0;
      bus.up_write = '0; bus.up_read_req = '0; bus.up_read = '0;
      bus.dn_write_rdy = 1'b0; bus.dn_read_rdy = 1'b0;

      //                      wm     rm     wr     rq     rd     wi ri  g      b  dn        wro    rro
      vecs.push_back(vec_t'{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 5'b00000, 2'b00, 2'b00}); // 0 reset state
      vecs.push_back(vec_t'{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 5'b00000, 2'b00, 2'b00}); // 1 both request
      vecs.push_back(vec_t'{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, 1, 5'b10000, 2'b00, 2'b00}); // 2 P0 wins
      vecs.push_back(vec_t'{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, 1, 5'b00000, 2'b00, 2'b00}); // 3 P0 drops
      vecs.push_back(vec_t'{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1, 5'b00000, 2'b00, 2'b00}); // 4 gap
      vecs.push_back(vec_t'{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1, 5'b00000, 2'b00, 2'b00}); // 5 gap
      vecs.push_back(vec_t'{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 5'b00000, 2'b00, 2'b00}); // 6 idle
      vecs.push_back(vec_t'{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b10, 1, 5'b10000, 2'b00, 2'b00}); // 7 P1 owns
      vecs.push_back(vec_t'{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 2'b10, 1, 5'b01010, 2'b00, 2'b00}); // 8 P1 -> read
      vecs.push_back(vec_t'{2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 0, 1, 2'b10, 1, 5'b01001, 2'b00, 2'b10}); // 9 P0 waits
      vecs.push_back(vec_t'{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 2'b10, 1, 5'b01000, 2'b00, 2'b00}); // 10
      vecs.push_back(vec_t'{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b10, 1, 5'b00000, 2'b00, 2'b00}); // 11 P1 drops
      vecs.push_back(vec_t'{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1, 5'b00000, 2'b00, 2'b00}); // 12 gap
      vecs.push_back(vec_t'{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1, 5'b00000, 2'b00, 2'b00}); // 13 gap
      vecs.push_back(vec_t'{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 5'b00000, 2'b00, 2'b00}); // 14 idle
      vecs.push_back(vec_t'{2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 1, 0, 2'b01, 1, 5'b10100, 2'b01, 2'b00}); // 15 word 1
      vecs.push_back(vec_t'{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b01, 1, 5'b10000, 2'b01, 2'b00}); // 16
      vecs.push_back(vec_t'{2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 2'b01, 1, 5'b10100, 2'b00, 2'b00}); // 17 word 2
      vecs.push_back(vec_t'{2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 2'b01, 1, 5'b10100, 2'b01, 2'b00}); // 18 word 3, P1 blocked
      vecs.push_back(vec_t'{2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 2'b01, 1, 5'b01000, 2'b01, 2'b00}); // 19 read beats write
      vecs.push_back(vec_t'{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, 1, 5'b00000, 2'b00, 2'b00}); // 20 P0 drops
      vecs.push_back(vec_t'{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1, 5'b00000, 2'b00, 2'b00}); // 21 gap
      vecs.push_back(vec_t'{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1, 5'b00000, 2'b00, 2'b00}); // 22 gap
      vecs.push_back(vec_t'{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 5'b00000, 2'b00, 2'b00}); // 23 idle
      vecs.push_back(vec_t'{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b10, 1, 5'b10000, 2'b00, 2'b00}); // 24 P1 owns
      vecs.push_back(vec_t'{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b10, 1, 5'b00000, 2'b00, 2'b00}); // 25 P1 drops
      vecs.push_back(vec_t'{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1, 5'b00000, 2'b00, 2'b00}); // 26 gap
      vecs.push_back(vec_t'{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1, 5'b00000, 2'b00, 2'b00}); // 27 gap
      vecs.push_back(vec_t'{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 5'b00000, 2'b00, 2'b00}); // 28 idle

      repeat (3) @(negedge ifclk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         @(negedge ifclk);
         bus.up_write_mode = vecs[i].wm;  bus.up_read_mode = vecs[i].rm;
         bus.up_write      = vecs[i].wr;  bus.up_read_req  = vecs[i].rq;
         bus.up_read       = vecs[i].rd;
         bus.dn_write_rdy  = vecs[i].wi;  bus.dn_read_rdy  = vecs[i].ri;
         #1;
         e_len  = (vecs[i].g == 2'b01) ? 32'd3 : (vecs[i].g == 2'b10) ? 32'd7 : 32'd0;
         e_di   = (vecs[i].g == 2'b01) ? DI0 : (vecs[i].g == 2'b10) ? DI1 : 32'd0;
         e_do   = {(vecs[i].g[1] ? DO_VAL : 32'd0), (vecs[i].g[0] ? DO_VAL : 32'd0)};
         dn_act = {bus.dn_write_mode, bus.dn_read_mode, bus.dn_write, bus.dn_read_req, bus.dn_read};
         chk($sformatf("r%0d_grant", i), 64'(bus.grant), 64'(vecs[i].g));
         chk($sformatf("r%0d_busy", i),  64'(bus.busy), 64'(vecs[i].b));
         chk($sformatf("r%0d_dn", i),    64'(dn_act), 64'(vecs[i].dn));
         chk($sformatf("r%0d_wrdy", i),  64'(bus.up_write_rdy), 64'(vecs[i].wro));
         chk($sformatf("r%0d_rrdy", i),  64'(bus.up_read_rdy), 64'(vecs[i].rro));
         chk($sformatf("r%0d_len", i),   64'(bus.dn_len), 64'(e_len));
         chk($sformatf("r%0d_datai", i), 64'(bus.dn_reg_datai), 64'(e_di));
         chk($sformatf("r%0d_datao", i), 64'(bus.up_reg_datao), e_do);
         chk($sformatf("r%0d_wdog", i),  64'(bus.wdog_pulse), 64'd0);
      end
      bus.up_write = '0; bus.up_read_req = '0; bus.up_read = '0;
      bus.dn_write_rdy = 1'b0; bus.dn_read_rdy = 1'b0;

      // both ports keep requesting; each owner releases for one cycle -> strict alternation
      exp_g = 2'b01;
      bus.up_write_mode = 2'b11;
      for (int n = 0; n < 8; n++) begin
         wait_grant(12, g);
         chk($sformatf("alt%0d_grant", n), 64'(g), 64'(exp_g));
         bus.up_write_mode = 2'b11 & ~exp_g;
         @(negedge ifclk); #1;
         bus.up_write_mode = (n < 7) ? 2'b11 : 2'b00;
         exp_g = {exp_g[0], exp_g[1]};
      end
      repeat (4) @(negedge ifclk);
      #1;
      chk("alt_end_idle", 64'(bus.busy), 64'd0);

      // watchdog: P0 holds write_mode with no strobes
      bus.up_write_mode = 2'b01;
      wait_grant(8, g);
      chk("wd_grant", 64'(g), 64'(2'b01));
      pulse_at = 0;
      for (int k = 1; k <= 20 && pulse_at == 0; k++) begin
         if (bus.wdog_pulse) pulse_at = k;
         else begin @(negedge ifclk); #1; end
      end
      chk("wd_pulse_cycle", 64'(pulse_at), 64'd16);
      bus.up_write_mode = 2'b11;      // P1 asks while P0 is locked out
      @(negedge ifclk); #1;
      chk("wd_pulse_one_cycle", 64'(bus.wdog_pulse), 64'd0);
      chk("wd_gap_grant", 64'(bus.grant), 64'd0);
      wait_grant(8, g);
      chk("wd_p1_served", 64'(g), 64'(2'b10));
      bus.up_write_mode = 2'b01;      // P1 releases, P0 still holding but locked
      repeat (6) @(negedge ifclk);
      #1;
      chk("wd_lock_grant", 64'(bus.grant), 64'd0);
      chk("wd_lock_busy", 64'(bus.busy), 64'd0);
      bus.up_write_mode = 2'b00;
      @(negedge ifclk); #1;
      bus.up_write_mode = 2'b01;
      wait_grant(8, g);
      chk("wd_p0_regrant", 64'(g), 64'(2'b01));
      bus.up_write_mode = 2'b00;
      repeat (4) @(negedge ifclk);
      #1;

      // asynchronous reset in the middle of a P1 read grant
      bus.up_read_mode = 2'b10;
      wait_grant(8, g);
      chk("rst_pre_grant", 64'(g), 64'(2'b10));
      chk("rst_pre_rmode", 64'(bus.dn_read_mode), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst_grant", 64'(bus.grant), 64'd0);
      chk("rst_rmode", 64'(bus.dn_read_mode), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      @(negedge ifclk); #1;
      reset = 1'b0;
      bus.up_read_mode = 2'b11;       // rr pointer back at 0 -> P0 first
      wait_grant(8, g);
      chk("rst_rr_zero", 64'(g), 64'(2'b01));
      bus.up_read_mode = 2'b00;
      repeat (2) @(negedge ifclk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
